cpu_execute_stage: RTL and testbench
====================================

# cpu_execute_stage

Execute stage of the in-order RV32 pipeline. It consumes the decode record and the forwarded operands produced by the forwarding unit, and computes one ALU, multiply, divide or branch result per instruction. It registers the result into the execute record, which feeds both the memory stage and the forwarding inputs. Multi-cycle multiply and divide stall upstream through `o_busy`.

## Interface
- `DIV_CYCLES`, default 32: radix-2 divider iterations; fixed at 32 for RV32.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_clock`  in  1: single clock; all state updates on its rising edge.
- `i_decode_data`  in  `decode_data_t`: `tag`, `pc`, `imm`, `alu_op`, `op_b_imm`, `inst_rd`, `have_rd`, `is_branch`, `is_jump`.
- `i_rs1`  in  32: forwarded rs1 value.
- `i_rs2`  in  32: forwarded rs2 value.
- `i_memory_busy`  in  1: memory stage cannot accept a new execute record.
- `o_execute_data`  out  `execute_data_t`: `tag`, `inst_rd`, `rd`, `jump`, `pc_next`.
- `o_busy`  out  1: execute stage is not accepting; decode must hold.

## Operation
- New instruction: `i_decode_data.tag != last_tag`. It is accepted only in the IDLE state with `i_memory_busy == 0`. On acceptance `last_tag <= i_decode_data.tag`.
- Operand B is `imm` when `op_b_imm` is set, otherwise `i_rs2`.
- Single-cycle ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA (shift amount = B[4:0]), SLT, SLTU, LUI (result = imm), AUIPC (result = pc + imm).
  - Result is registered on the acceptance edge.
  - `o_execute_data.tag` takes the accepted tag on that same edge.
- MUL, MULH, MULHSU, MULHU:
  - 33x33 signed product, registered in state MUL.
  - The selected half is written one cycle later.
- DIV, DIVU, REM, REMU:
  - Handed to sub-module `cpu_divide`; the stage waits in state DIV until done.
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
  - Both special cases complete in 1 cycle without iterating.
- Branches: compare `i_rs1` vs `i_rs2` (BEQ/BNE/BLT/BGE/BLTU/BGEU).
  - `jump` = 1 and `pc_next` = pc + imm when taken; otherwise `jump` = 0 and `pc_next` = pc + 4.
- JAL / JALR: `jump` = 1 and rd = pc + 4. `pc_next` = pc + imm for JAL, (rs1 + imm) & ~1 for JALR.
- No destination (`have_rd == 0`) or rd index 0: `inst_rd` = 0 and `rd` = 0, so forwarding of x0 always yields 0.
- FSM:
  - IDLE → MUL on a multiply. MUL → IDLE after the write cycle.
  - IDLE → DIV on a divide. DIV → IDLE on `cpu_divide.o_done`.
  - IDLE → IDLE on a single-cycle op.
- `o_execute_data` holds its value until the next result is written; no record is dropped or duplicated.

## Timing
- Reset: every `o_execute_data` field is 0, `last_tag` = 0, state IDLE, `o_busy` = 0, divider cleared.
- Reset during MUL or DIV aborts the operation; no partial result is ever written.
- Latency from acceptance edge to `o_execute_data` update:
  - single-cycle op: 1 clock.
  - multiply: 2 clocks.
  - divide: 34 clocks (1 setup, 32 iterations, 1 sign fix); special cases: 2 clocks.
- `o_busy` is combinational: (state != IDLE) or `i_memory_busy`. It deasserts in the cycle the MUL/DIV result is written.
- `i_memory_busy` high while MUL/DIV completes: the result is still written. Completion is not delayed; downstream holds it by tag.
- Back-to-back single-cycle ops with distinct tags: one accepted per clock, `o_busy` stays 0.
- Tag unchanged: nothing is accepted and outputs are unchanged.

## Structure
- `CPU_Types.sv` package:
  - `alu_op_t` enum, covering all ops listed above.
  - the added `decode_data_t` fields (`alu_op`, `op_b_imm`, `have_rd`, `is_branch`, `is_jump`).
  - `execute_data_t` with `jump` and `pc_next`.
- Sub-module `cpu_divide`:
  - Inputs: `i_clock`, `i_reset`, `i_start`, `i_signed`, `i_dividend`, `i_divisor`.
  - Outputs: `o_done` (1-cycle pulse), `o_quotient`, `o_remainder`.
  - Restoring radix-2 on magnitudes, with a sign fix at the end.

## Test plan
- Reset mid-stream: assert `i_reset` during DIV → next clock all outputs 0, `o_busy` 0. Post-reset ADD 1+2 with tag 1 → rd = 3, tag = 1 one clock later.
- Back-to-back: ADD (tag 1, 5+7), SUB (tag 2, 5−7), SLTU (tag 3, 1<0xFFFFFFFF) → rd = 12, 0xFFFFFFFE, 1 on three consecutive clocks, `o_busy` never high.
- MULH 0x80000000 × 0x80000000 → rd = 0x40000000 after 2 clocks, `o_busy` high exactly 1 clock. MULHU 0xFFFFFFFF² → 0xFFFFFFFE.
- DIV −7/2 → rd = −3 after 34 clocks; REM −7/2 → −1; DIVU 7/0 → 0xFFFFFFFF after 2 clocks; DIV 0x80000000/−1 → 0x80000000.
- Branches at pc 0x100, imm 0x20: BLT −1<1 → jump 1, pc_next 0x120. BGEU 0<1 → jump 0, pc_next 0x104. JALR rs1 0x203, imm 0 → pc_next 0x202, rd 0x104.
- Hold: `i_memory_busy` = 1 with a new tag → not accepted, outputs stable. Release → accepted next edge. Instruction with `inst_rd` = 0 → rd = 0.

Source files
------------

// File: rtl/cpu_execute_stage_pkg.sv
// Shared types for the RV32 execute stage: operation encoding, pipeline
// records and the stage FSM state.
package cpu_execute_stage_pkg;

    localparam int TAG_W = 8;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_AUIPC  = 5'd11,
        ALU_MUL    = 5'd12,
        ALU_MULH   = 5'd13,
        ALU_MULHSU = 5'd14,
        ALU_MULHU  = 5'd15,
        ALU_DIV    = 5'd16,
        ALU_DIVU   = 5'd17,
        ALU_REM    = 5'd18,
        ALU_REMU   = 5'd19,
        ALU_BEQ    = 5'd20,
        ALU_BNE    = 5'd21,
        ALU_BLT    = 5'd22,
        ALU_BGE    = 5'd23,
        ALU_BLTU   = 5'd24,
        ALU_BGEU   = 5'd25,
        ALU_JAL    = 5'd26,
        ALU_JALR   = 5'd27
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } exec_state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      pc;
        logic [31:0]      imm;
        alu_op_t          alu_op;
        logic             op_b_imm;
        logic [4:0]       inst_rd;
        logic             have_rd;
        logic             is_branch;
        logic             is_jump;
    } decode_data_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [4:0]       inst_rd;
        logic [31:0]      rd;
        logic             jump;
        logic [31:0]      pc_next;
    } execute_data_t;

    function automatic logic op_is_mul(input alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    endfunction

    function automatic logic op_is_div(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/cpu_execute_stage_divide.sv
// Restoring radix-2 divider on operand magnitudes with a final sign fix.
// Divide-by-zero and signed overflow resolve at start without iterating.
module cpu_divide
    import cpu_execute_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_done,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);
    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    logic          run_r, done_r, neg_q_r, neg_r_r;
    logic [CW-1:0] cnt_r;
    logic [31:0]   quo_r, rem_r, dvs_r;
    logic          dvd_neg_s, dvs_neg_s;
    logic [31:0]   dvd_mag_s, dvs_mag_s;
    logic [32:0]   shifted_s, diff_s;

    assign dvd_neg_s = i_signed && i_dividend[31];
    assign dvs_neg_s = i_signed && i_divisor[31];
    assign dvd_mag_s = dvd_neg_s ? (32'd0 - i_dividend) : i_dividend;
    assign dvs_mag_s = dvs_neg_s ? (32'd0 - i_divisor) : i_divisor;
    assign shifted_s = {rem_r, quo_r[31]};
    assign diff_s    = shifted_s - {1'b0, dvs_r};

    // Start/iterate/finish sequencing of the divider
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            cnt_r   <= '0;
            quo_r   <= 32'd0;
            rem_r   <= 32'd0;
            dvs_r   <= 32'd0;
        end else if (i_start) begin
            cnt_r <= '0;
            if (i_divisor == 32'd0) begin
                quo_r   <= 32'hFFFF_FFFF;
                rem_r   <= i_dividend;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
                run_r   <= 1'b0;
                done_r  <= 1'b1;
            end else if (i_signed && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF)) begin
                quo_r   <= 32'h8000_0000;
                rem_r   <= 32'd0;
                neg_q_r <= 1'b0;
                neg_r_r <= 1'b0;
                run_r   <= 1'b0;
                done_r  <= 1'b1;
            end else begin
                quo_r   <= dvd_mag_s;
                rem_r   <= 32'd0;
                dvs_r   <= dvs_mag_s;
                neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                neg_r_r <= dvd_neg_s;
                run_r   <= 1'b1;
                done_r  <= 1'b0;
            end
        end else if (run_r) begin
            if (!diff_s[32]) begin
                rem_r <= diff_s[31:0];
                quo_r <= {quo_r[30:0], 1'b1};
            end else begin
                rem_r <= shifted_s[31:0];
                quo_r <= {quo_r[30:0], 1'b0};
            end
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CW'(DIV_CYCLES - 1)) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    // Sign fix applied combinationally in the done cycle
    always_comb begin
        o_done      = done_r;
        o_quotient  = neg_q_r ? (32'd0 - quo_r) : quo_r;
        o_remainder = neg_r_r ? (32'd0 - rem_r) : rem_r;
    end

endmodule

// File: rtl/cpu_execute_stage.sv
// RV32 execute stage: single-cycle ALU/branch/jump, two-cycle multiply and
// iterative divide, all written into one registered execute record.
module cpu_execute_stage
    import cpu_execute_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic          i_reset,
    input  logic          i_clock,
    input  decode_data_t  i_decode_data,
    input  logic [31:0]   i_rs1,
    input  logic [31:0]   i_rs2,
    input  logic          i_memory_busy,
    output execute_data_t o_execute_data,
    output logic          o_busy
);
    exec_state_t      state_r, state_s;
    logic [TAG_W-1:0] last_tag_r, pend_tag_r;
    logic [4:0]       pend_rd_r, dest_s;
    alu_op_t          pend_op_r, op_s;
    logic [31:0]      pend_pc4_r, op_b_s, pc_plus4_s, alu_res_s, pc_next_s;
    logic             taken_s, jump_s, accept_s, is_mul_s, is_div_s;
    logic             mul_a_sign_s, mul_b_sign_s;
    logic [63:0]      mul_a_s, mul_b_s, prod_s, prod_r;
    logic             div_done_s;
    logic [31:0]      div_q_s, div_r_s;
    logic             wr_en_s;
    execute_data_t    wr_rec_s;

    assign op_s       = i_decode_data.alu_op;
    assign op_b_s     = i_decode_data.op_b_imm ? i_decode_data.imm : i_rs2;
    assign pc_plus4_s = i_decode_data.pc + 32'd4;
    assign dest_s     = i_decode_data.have_rd ? i_decode_data.inst_rd : 5'd0;
    assign is_mul_s   = op_is_mul(op_s);
    assign is_div_s   = op_is_div(op_s);
    assign accept_s   = (state_r == ST_IDLE) && !i_memory_busy && (i_decode_data.tag != last_tag_r);

    // Sign-extend to 64 bits so the low 64 bits of the product equal the 33x33 signed product
    assign mul_a_sign_s = ((op_s == ALU_MULH) || (op_s == ALU_MULHSU)) && i_rs1[31];
    assign mul_b_sign_s = (op_s == ALU_MULH) && op_b_s[31];
    assign mul_a_s      = {{32{mul_a_sign_s}}, i_rs1};
    assign mul_b_s      = {{32{mul_b_sign_s}}, op_b_s};
    assign prod_s       = mul_a_s * mul_b_s;

    cpu_divide #(.DIV_CYCLES(DIV_CYCLES)) u_divide (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (accept_s && is_div_s),
        .i_signed    ((op_s == ALU_DIV) || (op_s == ALU_REM)),
        .i_dividend  (i_rs1),
        .i_divisor   (op_b_s),
        .o_done      (div_done_s),
        .o_quotient  (div_q_s),
        .o_remainder (div_r_s)
    );

    // Single-cycle result, branch decision and next pc
    always_comb begin
        alu_res_s = 32'd0;
        taken_s   = 1'b0;
        jump_s    = 1'b0;
        pc_next_s = pc_plus4_s;
        case (op_s)
            ALU_ADD:   alu_res_s = i_rs1 + op_b_s;
            ALU_SUB:   alu_res_s = i_rs1 - op_b_s;
            ALU_AND:   alu_res_s = i_rs1 & op_b_s;
            ALU_OR:    alu_res_s = i_rs1 | op_b_s;
            ALU_XOR:   alu_res_s = i_rs1 ^ op_b_s;
            ALU_SLL:   alu_res_s = i_rs1 << op_b_s[4:0];
            ALU_SRL:   alu_res_s = i_rs1 >> op_b_s[4:0];
            ALU_SRA:   alu_res_s = $unsigned($signed(i_rs1) >>> op_b_s[4:0]);
            ALU_SLT:   alu_res_s = {31'd0, $signed(i_rs1) < $signed(op_b_s)};
            ALU_SLTU:  alu_res_s = {31'd0, i_rs1 < op_b_s};
            ALU_LUI:   alu_res_s = i_decode_data.imm;
            ALU_AUIPC: alu_res_s = i_decode_data.pc + i_decode_data.imm;
            ALU_BEQ:   taken_s = (i_rs1 == i_rs2);
            ALU_BNE:   taken_s = (i_rs1 != i_rs2);
            ALU_BLT:   taken_s = ($signed(i_rs1) < $signed(i_rs2));
            ALU_BGE:   taken_s = ($signed(i_rs1) >= $signed(i_rs2));
            ALU_BLTU:  taken_s = (i_rs1 < i_rs2);
            ALU_BGEU:  taken_s = (i_rs1 >= i_rs2);
            default:   alu_res_s = 32'd0;
        endcase
        if (i_decode_data.is_jump) begin
            jump_s    = 1'b1;
            alu_res_s = pc_plus4_s;
            pc_next_s = (op_s == ALU_JALR) ? ((i_rs1 + i_decode_data.imm) & ~32'd1)
                                           : (i_decode_data.pc + i_decode_data.imm);
        end else if (i_decode_data.is_branch && taken_s) begin
            jump_s    = 1'b1;
            pc_next_s = i_decode_data.pc + i_decode_data.imm;
        end else begin
            jump_s    = 1'b0;
        end
    end

    // Select which record, if any, is written this cycle
    always_comb begin
        wr_en_s  = 1'b0;
        wr_rec_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !is_mul_s && !is_div_s) begin
                    wr_en_s  = 1'b1;
                    wr_rec_s = '{tag: i_decode_data.tag, inst_rd: dest_s, rd: alu_res_s,
                                 jump: jump_s, pc_next: pc_next_s};
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_MUL: begin
                wr_en_s  = 1'b1;
                wr_rec_s = '{tag: pend_tag_r, inst_rd: pend_rd_r,
                             rd: (pend_op_r == ALU_MUL) ? prod_r[31:0] : prod_r[63:32],
                             jump: 1'b0, pc_next: pend_pc4_r};
            end
            ST_DIV: begin
                if (div_done_s) begin
                    wr_en_s  = 1'b1;
                    wr_rec_s = '{tag: pend_tag_r, inst_rd: pend_rd_r,
                                 rd: ((pend_op_r == ALU_DIV) || (pend_op_r == ALU_DIVU)) ? div_q_s : div_r_s,
                                 jump: 1'b0, pc_next: pend_pc4_r};
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: wr_en_s = 1'b0;
        endcase
        // x0 never carries a value into forwarding
        if (wr_rec_s.inst_rd == 5'd0) begin
            wr_rec_s.rd = 32'd0;
        end else begin
            wr_rec_s.rd = wr_rec_s.rd;
        end
    end

    // Execute record, accepted-tag tracking and multi-cycle context
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_execute_data <= '0;
            last_tag_r     <= '0;
            pend_tag_r     <= '0;
            pend_rd_r      <= 5'd0;
            pend_op_r      <= ALU_ADD;
            pend_pc4_r     <= 32'd0;
            prod_r         <= 64'd0;
        end else begin
            if (accept_s) begin
                last_tag_r <= i_decode_data.tag;
                pend_tag_r <= i_decode_data.tag;
                pend_rd_r  <= dest_s;
                pend_op_r  <= op_s;
                pend_pc4_r <= pc_plus4_s;
                prod_r     <= prod_s;
            end
            if (wr_en_s) begin
                o_execute_data <= wr_rec_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_s = ST_MUL;
                end else if (accept_s && is_div_s) begin
                    state_s = ST_DIV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL:  state_s = ST_IDLE;
            ST_DIV: begin
                if (div_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_busy = (state_r != ST_IDLE) || i_memory_busy;
    end

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Directed scoreboard bench for cpu_execute_stage: expected records are queued
// at issue and checked, with latency and busy profile, when the tag appears.
module tb_cpu_execute_stage;
    import cpu_execute_stage_pkg::*;

    logic          clock = 1'b0;
    logic          reset;
    decode_data_t  dec;
    logic [31:0]   rs1, rs2;
    logic          mem_busy;
    execute_data_t ex;
    logic          busy;

    int               n_cmp = 0;
    int               n_bad = 0;
    execute_data_t    exp_q[$];
    execute_data_t    last_rec;
    logic [TAG_W-1:0] tag_cnt;

    cpu_execute_stage #(.DIV_CYCLES(32)) dut (
        .i_reset        (reset),
        .i_clock        (clock),
        .i_decode_data  (dec),
        .i_rs1          (rs1),
        .i_rs2          (rs2),
        .i_memory_busy  (mem_busy),
        .o_execute_data (ex),
        .o_busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic cmp_int(input string name, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cmp_rec(input string name, input execute_data_t got, input execute_data_t want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed tag=%0d rd_idx=%0d rd=%08h jump=%0d pc_next=%08h expected tag=%0d rd_idx=%0d rd=%08h jump=%0d pc_next=%08h",
                   name, got.tag, got.inst_rd, got.rd, got.jump, got.pc_next,
                   want.tag, want.inst_rd, want.rd, want.jump, want.pc_next);
        end
    endtask

    task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic bimm, input logic [31:0] pc,
                         input logic [4:0] rd_idx, input logic hrd,
                         input logic [31:0] exp_rd, input logic exp_j, input logic [31:0] exp_pcn);
        execute_data_t e;
        tag_cnt       = tag_cnt + 8'd1;
        dec           = '0;
        dec.tag       = tag_cnt;
        dec.pc        = pc;
        dec.imm       = imm;
        dec.alu_op    = op;
        dec.op_b_imm  = bimm;
        dec.inst_rd   = rd_idx;
        dec.have_rd   = hrd;
        dec.is_branch = op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        dec.is_jump   = op inside {ALU_JAL, ALU_JALR};
        rs1           = a;
        rs2           = b;
        e.tag         = tag_cnt;
        e.inst_rd     = (hrd && (rd_idx != 5'd0)) ? rd_idx : 5'd0;
        e.rd          = exp_rd;
        e.jump        = exp_j;
        e.pc_next     = exp_pcn;
        exp_q.push_back(e);
    endtask

    // exp_busy < 0 skips the busy-profile checks
    task automatic wait_out(input string name, input int lat, input int exp_busy);
        int            cycles = 0;
        int            busy_cycles = 0;
        execute_data_t want;
        want = exp_q[0];
        while ((ex.tag !== want.tag) && (cycles < 60)) begin
            @(posedge clock);
            #1;
            cycles++;
            if ((ex.tag !== want.tag) && busy) busy_cycles++;
        end
        void'(exp_q.pop_front());
        cmp_int({name, "_latency"}, cycles, lat);
        if (exp_busy >= 0) begin
            cmp_int({name, "_busy_cycles"}, busy_cycles, exp_busy);
            cmp_int({name, "_busy_at_write"}, int'(busy), 0);
        end
        cmp_rec(name, ex, want);
        last_rec = want;
    endtask

    initial begin
        reset    = 1'b1;
        dec      = '0;
        rs1      = 32'd0;
        rs2      = 32'd0;
        mem_busy = 1'b0;
        tag_cnt  = '0;
        last_rec = '0;
        repeat (2) @(posedge clock);
        #1;
        cmp_rec("reset_record", ex, '0);
        cmp_int("reset_busy", int'(busy), 0);
        reset = 1'b0;

        // Reset in the middle of a divide
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'h40, 5'd3, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h44);
        repeat (5) begin
            @(posedge clock);
            #1;
        end
        cmp_int("div_busy_mid", int'(busy), 1);
        reset = 1'b1;
        dec   = '0;
        @(posedge clock);
        #1;
        cmp_rec("reset_mid_div_record", ex, '0);
        cmp_int("reset_mid_div_busy", int'(busy), 0);
        exp_q.delete();
        tag_cnt = '0;
        reset   = 1'b0;

        issue(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 32'h40, 5'd5, 1'b1, 32'd3, 1'b0, 32'h44);
        wait_out("post_reset_add", 1, 0);

        // Back-to-back single-cycle ops
        issue(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 32'h40, 5'd6, 1'b1, 32'd12, 1'b0, 32'h44);
        wait_out("b2b_add", 1, 0);
        issue(ALU_SUB, 32'd5, 32'd7, 32'd0, 1'b0, 32'h40, 5'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h44);
        wait_out("b2b_sub", 1, 0);
        issue(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h40, 5'd8, 1'b1, 32'd1, 1'b0, 32'h44);
        wait_out("b2b_sltu", 1, 0);
        issue(ALU_SRA, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 32'h40, 5'd9, 1'b1, 32'hF800_0000, 1'b0, 32'h44);
        wait_out("sra_imm", 1, 0);
        issue(ALU_AUIPC, 32'd0, 32'd0, 32'h1000, 1'b1, 32'h40, 5'd10, 1'b1, 32'h1040, 1'b0, 32'h44);
        wait_out("auipc", 1, 0);

        // Multiplies
        issue(ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 32'h40, 5'd11, 1'b1, 32'h4000_0000, 1'b0, 32'h44);
        wait_out("mulh", 2, 1);
        issue(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h40, 5'd12, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h44);
        wait_out("mulhu", 2, 1);
        issue(ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 32'h40, 5'd13, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h44);
        wait_out("mulhsu", 2, 1);
        issue(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 32'h40, 5'd14, 1'b1, 32'd42, 1'b0, 32'h44);
        @(posedge clock);
        #1;
        mem_busy = 1'b1;
        wait_out("mul_under_mem_busy", 1, -1);
        mem_busy = 1'b0;

        // Divides, including the single-step special cases
        issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'h40, 5'd15, 1'b1, 32'hFFFF_FFFD, 1'b0, 32'h44);
        wait_out("div_neg7_2", 34, 33);
        issue(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0, 32'h40, 5'd16, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h44);
        wait_out("rem_neg7_2", 34, 33);
        issue(ALU_REMU, 32'd100, 32'd7, 32'd0, 1'b0, 32'h40, 5'd17, 1'b1, 32'd2, 1'b0, 32'h44);
        wait_out("remu_100_7", 34, 33);
        issue(ALU_DIVU, 32'd7, 32'd0, 32'd0, 1'b0, 32'h40, 5'd18, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h44);
        wait_out("divu_by_zero", 2, 1);
        issue(ALU_REMU, 32'd7, 32'd0, 32'd0, 1'b0, 32'h40, 5'd19, 1'b1, 32'd7, 1'b0, 32'h44);
        wait_out("remu_by_zero", 2, 1);
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h40, 5'd20, 1'b1, 32'h8000_0000, 1'b0, 32'h44);
        wait_out("div_overflow", 2, 1);

        // Branches and jumps
        issue(ALU_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b1, 32'h100, 5'd0, 1'b0, 32'd0, 1'b1, 32'h120);
        wait_out("blt_taken", 1, 0);
        issue(ALU_BGEU, 32'd0, 32'd1, 32'h20, 1'b1, 32'h100, 5'd0, 1'b0, 32'd0, 1'b0, 32'h104);
        wait_out("bgeu_not_taken", 1, 0);
        issue(ALU_JALR, 32'h203, 32'd0, 32'd0, 1'b1, 32'h100, 5'd1, 1'b1, 32'h104, 1'b1, 32'h202);
        wait_out("jalr", 1, 0);

        // Memory stage holding: new tag must wait
        mem_busy = 1'b1;
        issue(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 32'h40, 5'd21, 1'b1, 32'd5, 1'b0, 32'h44);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            cmp_rec("hold_record_stable", ex, last_rec);
            cmp_int("hold_busy", int'(busy), 1);
        end
        mem_busy = 1'b0;
        wait_out("hold_release", 1, 0);

        // Destination x0 reads back as zero
        issue(ALU_ADD, 32'd5, 32'd5, 32'd0, 1'b0, 32'h40, 5'd0, 1'b1, 32'd0, 1'b0, 32'h44);
        wait_out("rd_x0", 1, 0);

        // Unchanged tag is not re-accepted
        repeat (3) @(posedge clock);
        #1;
        cmp_rec("same_tag_stable", ex, last_rec);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
